pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, branch flushes and
// memory-wait stalls with a timeout that raises a one-cycle mem_err.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rdata1D,
    input  logic [4:0]  rdata2D,
    input  logic [4:0]  waddrE,
    input  logic        reg_wrE,
    input  logic [1:0]  wb_selE,
    input  logic        pc_srcE,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    // state    | meaning
    // RUN      | normal issue; hazards decoded from D/E/M stage inputs
    // MEM_WAIT | data memory outstanding, whole pipe frozen, W bubbled
    // ERR      | one-cycle memory timeout report, front of pipe flushed
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_e;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lw_hazard;
    logic        any_stall;

    // Register x0 never carries a real dependency.
    always_comb begin
        lw_hazard = (wb_selE == 2'b10) && reg_wrE && (waddrE != 5'd0) &&
                    (((waddrE == rdata1D) && (rdata1D != 5'd0)) ||
                     ((waddrE == rdata2D) && (rdata2D != 5'd0)));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        flushW     = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    stallF     = 1'b1;
                    stallD     = 1'b1;
                    stallE     = 1'b1;
                    stallM     = 1'b1;
                    flushW     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end else if (pc_srcE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (lw_hazard) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            MEM_WAIT: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
                // A late ack still wins over the timeout in the same cycle.
                if (dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q >= TIMEOUT_W) begin
                    state_d    = ERR;
                    wait_cnt_d = 16'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ERR: begin
                mem_err = 1'b1;
                flushD  = 1'b1;
                flushE  = 1'b1;
                flushM  = 1'b1;
                flushW  = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    always_comb begin
        any_stall   = stallF | stallD | stallE | stallM;
        stall_cnt_d = stall_cnt_q;
        if (any_stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=8; expected output
// vectors are hand-derived as {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,mem_err}.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rdata1D = '0, rdata2D = '0, waddrE = '0;
    logic        reg_wrE = 1'b0;
    logic [1:0]  wb_selE = '0;
    logic        pc_srcE = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushM, flushW, mem_err;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    localparam logic [8:0] O_IDLE = 9'b0000_0000_0;
    localparam logic [8:0] O_LU   = 9'b1100_0100_0;
    localparam logic [8:0] O_BR   = 9'b0000_1100_0;
    localparam logic [8:0] O_MEM  = 9'b1111_0001_0;
    localparam logic [8:0] O_ERR  = 9'b0000_1111_1;

    pipeline_hazard_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rdata1D(rdata1D), .rdata2D(rdata2D), .waddrE(waddrE),
        .reg_wrE(reg_wrE), .wb_selE(wb_selE), .pc_srcE(pc_srcE),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mem_err};
    endfunction

    task automatic chk_o(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = outs();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        tests++;
        assert (stall_cnt === exp) else begin
            fails++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wb, input logic wr, input logic [4:0] wa,
                         input logic [4:0] r1, input logic [4:0] r2, input logic br,
                         input logic req, input logic ack);
        @(negedge clk);
        wb_selE = wb; reg_wrE = wr; waddrE = wa; rdata1D = r1; rdata2D = r2;
        pc_srcE = br; dmem_req = req; dmem_ack = ack;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset: RUN decode of inputs while held in reset.
        #2;
        chk_o("reset_idle", O_IDLE);
        chk_cnt("reset_cnt", 16'd0);
        dmem_req = 1'b1; #1;
        chk_o("reset_run_decode", O_MEM);
        dmem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1; chk_cnt("reset_cnt_held", 16'd0);
        @(negedge clk); rst_n = 1'b1;

        idle();
        chk_o("idle", O_IDLE);

        // Load-use via rs1, then via rs2.
        drive(2'b10, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_o("lu_rs1", O_LU);
        idle();
        chk_o("lu_one_cycle", O_IDLE);
        chk_cnt("lu_cnt", 16'd1);
        drive(2'b10, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
        chk_o("lu_rs2", O_LU);

        // Non-hazards.
        drive(2'b10, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_o("x0_hazard", O_IDLE);
        chk_cnt("x0_cnt", 16'd2);
        drive(2'b10, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_o("no_regwr", O_IDLE);
        drive(2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_o("not_load", O_IDLE);

        // Branch beats load-use.
        drive(2'b10, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        chk_o("branch_vs_lu", O_BR);

        // Memory hit has no latency.
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_o("mem_hit", O_IDLE);
        chk_cnt("after_branch_cnt", 16'd2);

        // Memory wait: ack on third MEM_WAIT cycle; branch/hazard ignored inside.
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_o("mem_run_stall", O_MEM);
        drive(2'b10, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        chk_o("mem_wait1_ignore", O_MEM);
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_o("mem_wait2", O_MEM);
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_o("mem_wait3_ack", O_MEM);
        idle();
        chk_o("mem_back_run", O_IDLE);
        chk_cnt("mem_cnt", 16'd6);

        // Timeout: RUN stall + 8 MEM_WAIT cycles, then ERR.
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_o("to_run_stall", O_MEM);
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk_o($sformatf("to_wait%0d", i + 1), O_MEM);
        end
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_o("to_err", O_ERR);
        idle();
        chk_o("to_back_run", O_IDLE);
        chk_cnt("to_cnt", 16'd15);

        // Ack in the same cycle the counter hits TIMEOUT: no error.
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_o("ack_at_timeout", O_MEM);
        idle();
        chk_o("ack_wins_no_err", O_IDLE);
        chk_cnt("ack_wins_cnt", 16'd24);

        // Saturation: 70000 load-use stall cycles.
        drive(2'b10, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        chk_cnt("saturate", 16'hFFFF);
        chk_o("sat_lu_still", O_LU);

        // Asynchronous reset in the middle of MEM_WAIT.
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_o("pre_reset_wait", O_MEM);
        rst_n = 1'b0;
        #1;
        chk_o("async_reset_run", O_IDLE);
        chk_cnt("async_reset_cnt", 16'd0);
        @(negedge clk); rst_n = 1'b1;
        idle();
        chk_o("post_reset1", O_IDLE);
        idle();
        chk_o("post_reset2_no_err", O_IDLE);
        chk_cnt("post_reset_cnt", 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
